// File: rtl/registerfile_param.sv
// Parametrised two-read-port register file with registered reads, an optional
// hardwired-zero register 0 and a hardware clear sweep (busy/done handshake).
// Configuration macro: REGFILE_BYPASS_EN -- when defined, a read that hits the
// address being written on the same edge captures the new write data;
// otherwise reads are read-before-write.
module registerfile_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDRW    = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             writeen,
  input  logic [ADDRW-1:0] writeaddr,
  input  logic [WIDTH-1:0] writedata,
  input  logic [ADDRW-1:0] readaddrA,
  input  logic [ADDRW-1:0] readaddrB,
  input  logic             clearreq,
  output logic [WIDTH-1:0] outdataA,
  output logic [WIDTH-1:0] outdataB,
  output logic             busy,
  output logic             done,
  output logic             wrdrop
);

  localparam int unsigned DEPTH = 2 ** ADDRW;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_a_q, rd_a_d;
  logic [WIDTH-1:0] rd_b_q, rd_b_d;
  logic             done_q, done_d;
  logic             wrdrop_q, wrdrop_d;

  logic busy_int;
  logic wr_to_r0;
  logic wr_commit;
  logic last_ptr;

  assign busy_int  = (state_q == StClear);
  assign wr_to_r0  = (ZERO_REG != 0) && (writeaddr == '0);
  assign wr_commit = writeen && !busy_int && !wr_to_r0;
  assign last_ptr  = (ptr_q == ADDRW'(DEPTH - 1));

  // Clear-sweep FSM: next state, sweep pointer and done pulse.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clearreq) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        ptr_d = ptr_q + ADDRW'(1);
        if (last_ptr) begin
          state_d = StIdle;
          ptr_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  // Writes arriving during a sweep are discarded and flagged; r0 writes stay silent.
  always_comb begin
    wrdrop_d = writeen && busy_int && !wr_to_r0;
  end

  // Storage next state: the sweep owns the array while busy, user writes otherwise.
  always_comb begin
    mem_d = mem_q;
    if (busy_int) begin
      mem_d[ptr_q] = '0;
    end else if (wr_commit) begin
      mem_d[writeaddr] = writedata;
    end
  end

  // Read port next state: optional same-edge forwarding, then the r0 override.
  always_comb begin
    rd_a_d = mem_q[readaddrA];
    rd_b_d = mem_q[readaddrB];
`ifdef REGFILE_BYPASS_EN
    if (wr_commit && (writeaddr == readaddrA)) rd_a_d = writedata;
    if (wr_commit && (writeaddr == readaddrB)) rd_b_d = writedata;
`else
    // Read-before-write: ports always see the pre-edge contents.
`endif
    if ((ZERO_REG != 0) && (readaddrA == '0)) rd_a_d = '0;
    if ((ZERO_REG != 0) && (readaddrB == '0)) rd_b_d = '0;
  end

  // State registers; asynchronous reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      done_q   <= 1'b0;
      wrdrop_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
      done_q   <= done_d;
      wrdrop_q <= wrdrop_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign outdataA = rd_a_q;
  assign outdataB = rd_b_q;
  assign busy     = busy_int;
  assign done     = done_q;
  assign wrdrop   = wrdrop_q;

endmodule

// File: tb/tb_registerfile_param.sv
// Bench for registerfile_param: ZERO_REG=1 (dut0) and ZERO_REG=0 (dut1) share
// all stimulus. Expectations track REGFILE_BYPASS_EN.
module tb_registerfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        writeen;
  logic [3:0]  writeaddr;
  logic [15:0] writedata;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic        clearreq;
  logic [15:0] out_a0, out_b0, out_a1, out_b1;
  logic        busy0, done0, wrdrop0, busy1, done1, wrdrop1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  registerfile_param #(.WIDTH(16), .ADDRW(4), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .writeen(writeen), .writeaddr(writeaddr),
    .writedata(writedata), .readaddrA(raddr_a), .readaddrB(raddr_b),
    .clearreq(clearreq), .outdataA(out_a0), .outdataB(out_b0),
    .busy(busy0), .done(done0), .wrdrop(wrdrop0)
  );

  registerfile_param #(.WIDTH(16), .ADDRW(4), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .writeen(writeen), .writeaddr(writeaddr),
    .writedata(writedata), .readaddrA(raddr_a), .readaddrB(raddr_b),
    .clearreq(clearreq), .outdataA(out_a1), .outdataB(out_b1),
    .busy(busy1), .done(done1), .wrdrop(wrdrop1)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] ea0;
    logic [15:0] eb0;
    logic [15:0] ea1;
  } vec_t;

  typedef struct {
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [15:0] ea0, input logic [15:0] eb0,
                              input logic [15:0] ea1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1;
    return v;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb, input logic clr);
    writeen = we; writeaddr = wa; writedata = wd;
    raddr_a = ra; raddr_b = rb; clearreq = clr;
  endtask

  task automatic push_exp(input logic [15:0] a0, input logic [15:0] b0, input logic [15:0] a1);
    exp_t e;
    e.a0 = a0; e.b0 = b0; e.a1 = a1;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check16({tag, "_a0"}, out_a0, e.a0);
      check16({tag, "_b0"}, out_b0, e.b0);
      check16({tag, "_a1"}, out_a1, e.a1);
    end
  endtask

  // Read every address (A ascending, B descending) and compare against a computed value.
  task automatic read_all(input string tag, input bit cleared);
    logic [15:0] va, vb, va1;
    for (int i = 0; i < 16; i++) begin
      va  = cleared ? 16'h0 : 16'(i * 32'h1111);
      vb  = cleared ? 16'h0 : 16'((15 - i) * 32'h1111);
      va1 = cleared ? 16'h0 : ((i == 0) ? 16'h1234 : va);
      if (i == 0) va = 16'h0;
      if (i == 15) vb = 16'h0;
      drive(1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 1'b0);
      push_exp(va, vb, va1);
      tick();
      pop_cmp($sformatf("%s_%0d", tag, i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    int ndone;
    bit fell;

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
    #12;
    check16("rst_out_a0", out_a0, 16'h0);
    check16("rst_out_b0", out_b0, 16'h0);
    check1("rst_busy", busy0, 1'b0);
    check1("rst_done", done0, 1'b0);
    check1("rst_wrdrop", wrdrop0, 1'b0);
    check1("rst_busy1", busy1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic read/write, zero register and same-edge hazard vectors.
    vecs[0] = mk(1'b0, 4'd0, 16'h0000, 4'd0, 4'd15, 16'h0000, 16'h0000, 16'h0000);
    vecs[1] = mk(1'b1, 4'd5, 16'hBEEF, 4'd7, 4'd9,  16'h0000, 16'h0000, 16'h0000);
    vecs[2] = mk(1'b0, 4'd0, 16'h0000, 4'd5, 4'd5,  16'hBEEF, 16'hBEEF, 16'hBEEF);
    vecs[3] = mk(1'b1, 4'd0, 16'h1234, 4'd5, 4'd0,  16'hBEEF, 16'h0000, 16'hBEEF);
    vecs[4] = mk(1'b0, 4'd0, 16'h0000, 4'd0, 4'd5,  16'h0000, 16'hBEEF, 16'h1234);
    vecs[5] = mk(1'b1, 4'd3, 16'h00AA, 4'd0, 4'd3,  16'h0000, Byp ? 16'h00AA : 16'h0000,
                 16'h1234);
    vecs[6] = mk(1'b1, 4'd3, 16'h5555, 4'd3, 4'd5,  Byp ? 16'h5555 : 16'h00AA, 16'hBEEF,
                 Byp ? 16'h5555 : 16'h00AA);
    vecs[7] = mk(1'b0, 4'd0, 16'h0000, 4'd3, 4'd3,  16'h5555, 16'h5555, 16'h5555);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, 1'b0);
      push_exp(vecs[i].ea0, vecs[i].eb0, vecs[i].ea1);
      tick();
      pop_cmp($sformatf("vec%0d", i));
      check1($sformatf("vec%0d_wrdrop", i), wrdrop0, 1'b0);
    end

    // Exhaustive fill of r1..r15 then cross-port readback.
    for (int a = 1; a < 16; a++) begin
      drive(1'b1, 4'(a), 16'(a * 32'h1111), 4'd0, 4'd0, 1'b0);
      tick();
    end
    read_all("fill", 1'b0);

    // Clear sweep with a dropped mid-sweep write.
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'(a), 16'hFFFF, 4'd0, 4'd0, 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 16'h0, 4'd15, 4'd0, 1'b1);
    tick();
    check1("clr_busy_rise", busy0, 1'b1);
    check1("clr_done_low", done0, 1'b0);
    nbusy = 1;
    ndone = 0;
    fell  = 1'b0;
    for (int c = 1; c <= 40 && !fell; c++) begin
      if (c == 3) drive(1'b1, 4'd2, 16'hABCD, 4'd15, 4'd0, 1'b0);
      else        drive(1'b0, 4'd0, 16'h0, 4'd15, 4'd0, 1'b0);
      tick();
      if (c == 1) check16("clr_read_old", out_a0, 16'hFFFF);
      if (c == 3) check1("wrdrop_pulse", wrdrop0, 1'b1);
      if (c == 4) check1("wrdrop_once", wrdrop0, 1'b0);
      if (done0) ndone++;
      if (busy0) nbusy++;
      else begin
        fell = 1'b1;
        check1("done_at_fall", done0, 1'b1);
      end
    end
    check_int("busy_cycles", nbusy, 16);
    check_int("done_pulses", ndone, 1);
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
    tick();
    check1("done_cleared", done0, 1'b0);
    read_all("clr", 1'b1);

    // Reset at sweep cycle 7.
    drive(1'b1, 4'd9, 16'h7777, 4'd0, 4'd0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 16'h0, 4'd9, 4'd9, 1'b1);
    tick();
    drive(1'b0, 4'd0, 16'h0, 4'd9, 4'd9, 1'b0);
    for (int c = 0; c < 7; c++) tick();
    check16("pre_rst_data", out_a0, 16'h7777);
    check1("pre_rst_busy", busy0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("mid_rst_busy", busy0, 1'b0);
    check1("mid_rst_done", done0, 1'b0);
    check16("mid_rst_a0", out_a0, 16'h0);
    check16("mid_rst_b0", out_b0, 16'h0);
    check16("mid_rst_a1", out_a1, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check1("post_rst_idle", busy0, 1'b0);
    read_all("post_rst", 1'b1);
    check1("post_rst_still_idle", busy0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/registerfile_param.md
# registerfile_param

Parametrised successor to the 16x16 two-read-port register file. It adds an explicit write address, a configurable word width and register count, and a selectable hardwired-zero register 0. Both read ports are registered. A hardware clear engine sweeps every register to zero on request, with a busy/done handshake. The block sits between the decode stage and the ALU operand latches of the datapath.

## Interface
- `WIDTH`, 16, data word width in bits
- `ADDRW`, 4, address width; register count DEPTH = 2**ADDRW
- `ZERO_REG`, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `writeen`  in  1  write enable
- `writeaddr`  in  ADDRW  write address
- `writedata`  in  WIDTH  write data
- `readaddrA`  in  ADDRW  port A read address
- `readaddrB`  in  ADDRW  port B read address
- `clearreq`  in  1  request a full clear; level sampled in IDLE
- `outdataA`  out  WIDTH  registered port A read data
- `outdataB`  out  WIDTH  registered port B read data
- `busy`  out  1  clear sweep in progress
- `done`  out  1  one-cycle pulse when the sweep finishes
- `wrdrop`  out  1  one-cycle pulse: a write was discarded because `busy` was high

## Operation
- Storage: DEPTH x WIDTH flip-flops.
- Reset (`rst_n` low, asynchronous): all registers = 0, `outdataA`/`outdataB` = 0, `busy` = 0, `done` = 0, `wrdrop` = 0, FSM = IDLE, sweep pointer = 0. Deasserting reset mid-sweep leaves the FSM in IDLE; the sweep is not resumed.
- Write: on a rising edge with `writeen`=1, `busy`=0, and not (ZERO_REG=1 and `writeaddr`=0), `mem[writeaddr]` <= `writedata`. Writes to r0 with ZERO_REG=1 are silently ignored and do not pulse `wrdrop`.
- Read: every rising edge, `outdataX` <= `mem[readaddrX]`. It is forced to 0 when ZERO_REG=1 and `readaddrX`=0. Ports are independent and may use the same address.
- FSM states:
  - IDLE: `busy`=0. If `clearreq`=1, go to CLEAR with pointer=0.
  - CLEAR: `busy`=1. Each cycle, `mem[ptr]` <= 0 and ptr increments. When ptr = DEPTH-1, write 0, go to IDLE, and pulse `done` for one cycle coincident with `busy` falling.
- Sweep length is exactly DEPTH cycles. `clearreq` is ignored while in CLEAR.
- `writeen`=1 while `busy`=1: the write is discarded and `wrdrop`=1 the following cycle.
- `clearreq` and `writeen` together in IDLE: the write commits on that edge, and the sweep starts next cycle and overwrites it.
- Reads during CLEAR return current storage: zero for already-swept addresses, old data otherwise.
- Width rule: `writedata` is stored unmodified. There is no arithmetic and no truncation.

## Timing
- Read latency: 1 cycle. Address presented before edge N gives data on the outputs after edge N.
- Write-to-read: a write at edge N is visible to a read sampled at edge N+1. Same-edge behaviour is set by the configuration macro.
- `clearreq` sampled at edge N (IDLE) gives `busy`=1 after edge N and sweeps at edges N+1 .. N+DEPTH. After edge N+DEPTH, `busy`=0 and `done`=1 for one cycle.
- `wrdrop` asserts one cycle after the discarded write edge.

## Configuration
- `REGFILE_BYPASS_EN` defined: when a write commits to address X on edge N and `readaddrA`/`readaddrB` = X at the same edge, that port captures `writedata` (new-data forwarding). The ZERO_REG rule still forces 0 for address 0.
- Undefined: read-before-write. The port captures the old contents of X, and the new value appears on the next read.

## Test plan
- Reset and basic read/write: after reset both ports read 0 at all addresses. Write 0xBEEF to r5, then read A=5, B=5 → both 0xBEEF one cycle later.
- Zero register: ZERO_REG=1, write 0x1234 to r0 → A reads 0, and `wrdrop` stays 0. ZERO_REG=0 build → reads 0x1234.
- Exhaustive sweep: for each address 1..15 write value = addr*0x1111, then read back all addresses on A and B with different addresses per port. Every value matches, and no cross-register aliasing occurs.
- Same-edge hazard: r3=0x00AA, then write 0x5555 to r3 with readaddrA=3 on the same edge. Required result: 0x5555 with `REGFILE_BYPASS_EN`, 0x00AA without; 0x5555 on the next cycle in both builds.
- Clear sweep: fill all registers with 0xFFFF, pulse `clearreq`. Required: `busy` high for exactly 16 cycles, `done` pulses once, all reads return 0. A write issued mid-sweep is dropped, `wrdrop`=1 the next cycle, and the target reads 0.
- Reset mid-sweep: assert `rst_n`=0 at sweep cycle 7 → `busy`, `done` and outputs go to 0 immediately. After release, the FSM is in IDLE and all registers read 0.
